// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma -- OAM DMA engine.
//
// A CPU write to REG_ADDR latches the source page and starts a transfer. The
// engine waits START_DELAY clocks, then copies LENGTH bytes from
// {src_hi, idx} to DST_BASE+idx, spending CYCLES_PER_BYTE clocks per byte:
// phase 0 reads, phase 1 writes (single-clock strobe), later phases idle on
// the destination address. Source pages E0..FF fold onto C0..DF (echo RAM).
// A new trigger is accepted in any state and restarts from byte 0.
//
// Optional feature (macro DMA_CONFLICT_EN): registered bus_conflict pulse when
// the CPU writes outside HRAM (FF80..FFFE) while a transfer is active. With
// the macro undefined bus_conflict is tied low.
//
// Ports:
//   clk, reset_n        clock; asynchronous active-low reset
//   cpu_addr/data_w/we  snooped CPU bus (trigger detection, conflict check)
//   reg_data_r          register readback (updated on negedge clk)
//   dma_addr/data_w/we  initiator bus towards the memory responders
//   dma_data_r          responder read data (negedge-updated)
//   active              transfer in progress; top level grants the bus
//   bus_conflict        CPU touched non-HRAM during a transfer
// -----------------------------------------------------------------------------
module oam_dma #(
    parameter logic [15:0] REG_ADDR        = 16'hFF46,
    parameter logic [15:0] DST_BASE        = 16'hFE00,
    parameter int          LENGTH          = 160,
    parameter int          CYCLES_PER_BYTE = 4,
    parameter int          START_DELAY     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_w,
    input  logic        cpu_write_enable,
    output logic [7:0]  reg_data_r,
    output logic [15:0] dma_addr,
    input  logic [7:0]  dma_data_r,
    output logic [7:0]  dma_data_w,
    output logic        dma_write_enable,
    output logic        active,
    output logic        bus_conflict
);

    // One counter serves both the start delay and the per-byte phase.
    localparam int CNT_MAX = (START_DELAY > CYCLES_PER_BYTE) ? START_DELAY : CYCLES_PER_BYTE;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] START_LAST = CW'(START_DELAY - 1);
    localparam logic [CW-1:0] PHASE_LAST = CW'(CYCLES_PER_BYTE - 1);
    localparam logic [CW-1:0] PHASE_RD   = CW'(0);
    localparam logic [CW-1:0] PHASE_WR   = CW'(1);
    localparam logic [7:0]    LAST_IDX   = 8'(LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        COPY  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    src_hi_q, src_hi_d;
    logic [7:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    latch_q;
    logic [7:0]    src_page;
    logic          trigger;

    assign trigger  = cpu_write_enable && (cpu_addr == REG_ADDR);
    // Echo RAM E000..FDFF mirrors C000..DDFF.
    assign src_page = (src_hi_q >= 8'hE0) ? (src_hi_q - 8'h20) : src_hi_q;

    // Next-state logic.
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d  = state_q;
        src_hi_d = src_hi_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: ;
            START: begin
                if (cnt_q == START_LAST) begin
                    state_d = COPY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COPY: begin
                if (cnt_q == PHASE_LAST) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = 8'h00;
                    end else begin
                        idx_d = idx_q + 8'h01;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Trigger overrides whatever the engine was doing.
        if (trigger) begin
            state_d  = START;
            src_hi_d = cpu_data_w;
            idx_d    = 8'h00;
            cnt_d    = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            src_hi_q <= 8'h00;
            idx_q    <= 8'h00;
            cnt_q    <= '0;
            latch_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            src_hi_q <= src_hi_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            // Read data issued in phase 0 is valid at the closing posedge.
            if (state_q == COPY && cnt_q == PHASE_RD) begin
                latch_q <= dma_data_r;
            end
        end
    end

    // Bus outputs decode registered state only; cpu_* never reaches dma_*.
    always_comb begin
        dma_addr         = 16'h0000;
        dma_write_enable = 1'b0;
        if (state_q == COPY) begin
            if (cnt_q == PHASE_RD) begin
                dma_addr = {src_page, idx_q};
            end else begin
                dma_addr         = DST_BASE + {8'h00, idx_q};
                dma_write_enable = (cnt_q == PHASE_WR);
            end
        end
    end

    assign dma_data_w = latch_q;
    assign active     = (state_q != IDLE);

    // Readback follows the responder timing: updated on the falling edge.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_data_r <= 8'h00;
        end else begin
            reg_data_r <= src_hi_q;
        end
    end

`ifdef DMA_CONFLICT_EN
    logic cpu_in_hram;
    assign cpu_in_hram = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_conflict <= 1'b0;
        end else begin
            bus_conflict <= active && cpu_write_enable && !cpu_in_hram;
        end
    end
`else
    assign bus_conflict = 1'b0;
`endif

endmodule
